// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for a multi-cycle MIPS datapath (shared memory, ALU, IR, PC).
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and write-back phases. It waits in FETCH, MEMRD and MEMWR until the memory
// reports completion. A retired-instruction counter and an illegal-opcode
// flag are provided for debug.
//
// Supported opcodes: R-type, LW, SW, BEQ, J, ADDI.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   opcode[5:0]  in   IR[31:26], stable from DECODE onward
//   mem_ready    in   memory access completes this cycle
//   PCWrite      out  unconditional PC write
//   PCWriteCond  out  PC write when ALU zero
//   IorD         out  memory address select (0 = PC, 1 = ALUOut)
//   MemRead      out  memory read
//   MemWrite     out  memory write
//   IRWrite      out  IR load
//   MemtoReg     out  write-back select (0 = ALUOut, 1 = MDR)
//   RegDst       out  destination register (0 = rt, 1 = rd)
//   RegWrite     out  register file write
//   ALUSrcA      out  ALU A select (0 = PC, 1 = reg A)
//   ALUSrcB[1:0] out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   ALUOp[1:0]   out  00 add, 01 sub, 10 funct decode
//   PCSource[1:0]out  00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]   out  current state, debug
//   illegal_op   out  unknown opcode seen in DECODE
//   retired      out  retired-instruction count, wraps silently
//
// State table
//   code | state    | meaning
//   0    | FETCH    | read instruction at PC, PC <= PC + 4 on mem_ready
//   1    | DECODE   | register read, branch target precompute
//   2    | MEMADR   | effective address for LW / SW
//   3    | MEMRD    | load data read, wait for mem_ready
//   4    | MEMWB    | load write-back into rt
//   5    | MEMWR    | store, MemWrite held until mem_ready
//   6    | EXEC     | R-type ALU operation
//   7    | RTYPEWB  | R-type write-back into rd
//   8    | BRANCH   | BEQ compare and conditional PC write
//   9    | JUMP     | J target PC write
//   10   | ADDIEXEC | A + sign-extended immediate
//   11   | ADDIWB   | ADDI write-back into rt
//   12-15| (none)   | unreachable, recover to FETCH with all outputs low
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsource;
  logic       w_illegal;
  logic       w_retire;
  logic       w_known_op;

  assign w_known_op = (opcode == OP_RTYPE) || (opcode == OP_LW)  ||
                      (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                      (opcode == OP_J)     || (opcode == OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_pcsource    = 2'b00;
    w_illegal     = 1'b0;
    w_retire      = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        // PC and IR load are gated by mem_ready so a stalled fetch
        // updates them exactly once, on the completing cycle.
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEXEC;
          default:      w_next = S_FETCH;
        endcase
        w_illegal = !w_known_op;
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        // MemWrite stays high across wait states until memory accepts.
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // While reset is held every control output is forced low, so nothing
  // strobes the datapath before the first real FETCH after release.
  assign PCWrite     = rst_n & w_pcwrite;
  assign PCWriteCond = rst_n & w_pcwritecond;
  assign IorD        = rst_n & w_iord;
  assign MemRead     = rst_n & w_memread;
  assign MemWrite    = rst_n & w_memwrite;
  assign IRWrite     = rst_n & w_irwrite;
  assign MemtoReg    = rst_n & w_memtoreg;
  assign RegDst      = rst_n & w_regdst;
  assign RegWrite    = rst_n & w_regwrite;
  assign ALUSrcA     = rst_n & w_alusrca;
  assign ALUSrcB     = {2{rst_n}} & w_alusrcb;
  assign ALUOp       = {2{rst_n}} & w_aluop;
  assign PCSource    = {2{rst_n}} & w_pcsource;
  assign illegal_op  = rst_n & w_illegal;
  assign state       = r_state;
  assign retired     = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       illegal_op;
  logic [3:0] retired;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_ret;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  multicycle_control_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic mr);
    opcode = op;
    mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b1;
    #2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL reset_memread_forced got %b want 0", MemRead); end
    checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin errors++; $display("FAIL reset_irw_pcw_forced got %b%b want 00", IRWrite, PCWrite); end
    checks++; if (ALUSrcB !== 2'b00) begin errors++; $display("FAIL reset_alusrcb_forced got %b want 00", ALUSrcB); end
    tick(); tick();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_hold_state got %0d want 0", state); end
    rst_n = 1'b1;
    #1;
    checks++; if (MemRead !== 1'b1 || ALUSrcB !== 2'b01) begin errors++; $display("FAIL fetch_outputs got MemRead=%b ALUSrcB=%b want 1 01", MemRead, ALUSrcB); end
    checks++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin errors++; $display("FAIL fetch_ready_strobes got %b%b want 11", IRWrite, PCWrite); end
    mem_ready = 1'b0;
    #1;
    checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin errors++; $display("FAIL fetch_wait_strobes got %b%b want 00", IRWrite, PCWrite); end
    tick();
    exp_ret = 4'd0;
  endtask

  task automatic test_lw();
    logic [3:0] st [0:4];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 5; i++) begin
      drive(OP_LW, 1'b1);
      checks++; if (state !== st[i]) begin errors++; $display("FAIL lw_state cyc%0d got %0d want %0d", i, state, st[i]); end
      checks++; if (RegWrite !== (st[i] == 4'd4) || MemtoReg !== (st[i] == 4'd4)) begin errors++; $display("FAIL lw_wb cyc%0d got RegWrite=%b MemtoReg=%b", i, RegWrite, MemtoReg); end
      if (st[i] == 4'd3) begin
        checks++; if (MemRead !== 1'b1 || IorD !== 1'b1) begin errors++; $display("FAIL lw_memrd got MemRead=%b IorD=%b want 1 1", MemRead, IorD); end
      end
      if (st[i] == 4'd2) begin
        checks++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10) begin errors++; $display("FAIL lw_memadr got %b %b want 1 10", ALUSrcA, ALUSrcB); end
      end
      tick();
    end
    exp_ret = exp_ret + 4'd1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state got %0d want 0", state); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL lw_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] st [0:7];
    logic [5:0] op [0:7];
    st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd10, 4'd11};
    op = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    for (int i = 0; i < 8; i++) begin
      drive(op[i], 1'b1);
      checks++; if (state !== st[i]) begin errors++; $display("FAIL b2b_state cyc%0d got %0d want %0d", i, state, st[i]); end
      if (st[i] == 4'd6) begin
        checks++; if (ALUOp !== 2'b10 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin errors++; $display("FAIL exec_alu got ALUOp=%b A=%b B=%b", ALUOp, ALUSrcA, ALUSrcB); end
      end
      if (st[i] == 4'd7) begin
        checks++; if (RegDst !== 1'b1 || RegWrite !== 1'b1 || MemtoReg !== 1'b0) begin errors++; $display("FAIL rtypewb got RegDst=%b RegWrite=%b MemtoReg=%b want 1 1 0", RegDst, RegWrite, MemtoReg); end
      end
      if (st[i] == 4'd10) begin
        checks++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || RegWrite !== 1'b0) begin errors++; $display("FAIL addiexec got A=%b B=%b RegWrite=%b", ALUSrcA, ALUSrcB, RegWrite); end
      end
      if (st[i] == 4'd11) begin
        checks++; if (RegDst !== 1'b0 || RegWrite !== 1'b1) begin errors++; $display("FAIL addiwb got RegDst=%b RegWrite=%b want 0 1", RegDst, RegWrite); end
      end
      tick();
    end
    exp_ret = exp_ret + 4'd2;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL b2b_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_sw_wait();
    logic [3:0] st [0:6];
    logic       mr [0:6];
    logic       mw [0:6];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    mw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(OP_SW, mr[i]);
      checks++; if (state !== st[i]) begin errors++; $display("FAIL sw_state cyc%0d got %0d want %0d", i, state, st[i]); end
      checks++; if (MemWrite !== mw[i]) begin errors++; $display("FAIL sw_memwrite cyc%0d got %b want %b", i, MemWrite, mw[i]); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL sw_regwrite cyc%0d got %b want 0", i, RegWrite); end
      if (i == 6) begin
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL sw_retired_early got %0d want %0d", retired, exp_ret); end
      end
      tick();
    end
    exp_ret = exp_ret + 4'd1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_end_state got %0d want 0", state); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL sw_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_fetch_wait();
    logic [3:0] st [0:4];
    logic       mr [0:4];
    logic       irw [0:4];
    logic       pcw [0:4];
    st  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9};
    mr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    irw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pcw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(OP_J, mr[i]);
      checks++; if (state !== st[i]) begin errors++; $display("FAIL fwait_state cyc%0d got %0d want %0d", i, state, st[i]); end
      checks++; if (IRWrite !== irw[i] || PCWrite !== pcw[i]) begin errors++; $display("FAIL fwait_strobes cyc%0d got IRWrite=%b PCWrite=%b want %b %b", i, IRWrite, PCWrite, irw[i], pcw[i]); end
      tick();
    end
    exp_ret = exp_ret + 4'd1;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL fwait_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_branch_jump();
    logic [3:0] st [0:5];
    logic [5:0] op [0:5];
    st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
    op = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    for (int i = 0; i < 6; i++) begin
      drive(op[i], 1'b1);
      checks++; if (state !== st[i]) begin errors++; $display("FAIL bj_state cyc%0d got %0d want %0d", i, state, st[i]); end
      if (st[i] == 4'd1) begin
        checks++; if (ALUSrcB !== 2'b11 || ALUSrcA !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("FAIL decode_out got B=%b A=%b ill=%b", ALUSrcB, ALUSrcA, illegal_op); end
      end
      if (st[i] == 4'd8) begin
        checks++; if (PCWriteCond !== 1'b1 || PCSource !== 2'b01 || ALUOp !== 2'b01 || PCWrite !== 1'b0) begin errors++; $display("FAIL branch_out got PWC=%b PCSrc=%b ALUOp=%b PCW=%b", PCWriteCond, PCSource, ALUOp, PCWrite); end
      end
      if (st[i] == 4'd9) begin
        checks++; if (PCWrite !== 1'b1 || PCSource !== 2'b10 || PCWriteCond !== 1'b0) begin errors++; $display("FAIL jump_out got PCW=%b PCSrc=%b PWC=%b", PCWrite, PCSource, PCWriteCond); end
      end
      tick();
    end
    exp_ret = exp_ret + 4'd2;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL bj_end_state got %0d want 0", state); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL bj_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_illegal();
    drive(6'b111111, 1'b1);
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_fetch got %b want 0", illegal_op); end
    tick();
    drive(6'b111111, 1'b1);
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL ill_decode_state got %0d want 1", state); end
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", illegal_op); end
    tick();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL ill_next_state got %0d want 0", state); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL ill_retired got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_wrap();
    int n;
    n = 16 - int'(exp_ret);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 4; c++) begin
        drive(OP_ADDI, 1'b1);
        tick();
      end
      exp_ret = exp_ret + 4'd1;
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL wrap_retired addi%0d got %0d want %0d", k, retired, exp_ret); end
    end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", retired); end
  endtask

  task automatic test_reset_mid();
    drive(OP_RTYPE, 1'b1);
    tick();
    tick();
    checks++; if (state !== 4'd6) begin errors++; $display("FAIL rmid_exec got %0d want 6", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL rmid_state got %0d want 0", state); end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL rmid_retired got %0d want 0", retired); end
    checks++; if (ALUOp !== 2'b00 || ALUSrcA !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL rmid_outputs got ALUOp=%b A=%b RW=%b", ALUOp, ALUSrcA, RegWrite); end
    tick();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (state !== 4'd0 || MemRead !== 1'b1) begin errors++; $display("FAIL rmid_release got state=%0d MemRead=%b want 0 1", state, MemRead); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (state !== 4'd0 || RegWrite !== 1'b0) begin errors++; $display("FAIL rmid_no_wb cyc%0d got state=%0d RW=%b", i, state, RegWrite); end
    end
    exp_ret = 4'd0;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL rmid_retired_after got %0d want 0", retired); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_sw_wait();
    test_fetch_wait();
    test_branch_jump();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle MIPS controller. It sequences the shared datapath (one memory, one ALU, IR, PC) over several cycles per instruction using a Moore FSM with memory wait states.
- Supports the same instruction set as the single-cycle core: R-type, LW, SW, BEQ, J, ADDI.
- Sits between the IR opcode field and the datapath mux and enable controls.
- Also provides a retired-instruction counter and an illegal-opcode flag for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  PC write if ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read.
- MemWrite  out  1  memory write.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = reg A.
- ALUSrcB  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  unknown opcode seen in DECODE.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEXEC=10, ADDIWB=11. Codes 12-15 are unreachable; if entered, next state = FETCH and all outputs = 0.
- Reset (rst_n=0, asynchronous): state=FETCH, retired=0. While rst_n=0, all control outputs and illegal_op are forced to 0 combinationally. The first FETCH outputs appear after release.
- Transitions:
  - FETCH: to DECODE when mem_ready=1, else stay in FETCH.
  - DECODE by opcode:
    - 100011 (LW) or 101011 (SW): to MEMADR.
    - 000000 (R-type): to EXEC.
    - 000100 (BEQ): to BRANCH.
    - 000010 (J): to JUMP.
    - 001000 (ADDI): to ADDIEXEC.
    - other: to FETCH.
  - MEMADR: to MEMRD for LW, to MEMWR for SW.
  - MEMRD: to MEMWB when mem_ready=1, else stay.
  - MEMWR: to FETCH when mem_ready=1, else stay.
  - EXEC to RTYPEWB; ADDIEXEC to ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BRANCH, JUMP: to FETCH.
- Outputs per state (unlisted outputs are 0):
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal mem_ready (Mealy-gated), so the PC and IR update exactly once per fetch.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. illegal_op=1 if the opcode is unknown.
  - MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWR: MemWrite=1, IorD=1. MemWrite is held for the whole wait.
  - MEMWB: MemtoReg=1, RegDst=0, RegWrite=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
- RegWrite, PCWrite, PCWriteCond and MemWrite are single-cycle, except MemWrite during MEMWR wait states.
- Latency with mem_ready held at 1: LW 5 cycles, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Retired counter:
  - Increments by 1 on the clock edge leaving MEMWB, RTYPEWB, ADDIWB, BRANCH or JUMP, or leaving MEMWR with mem_ready=1.
  - Illegal opcodes do not increment it.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-instruction: immediate return to FETCH and counter cleared; no partial write-back is issued after release.

Test Plan:
- Reset, then LW (100011) with mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; retired=1 after 5 cycles.
- R-type (000000) then ADDI (001000) back-to-back → states 0,1,6,7 then 0,1,10,11; RegDst=1 in state 7, 0 in state 11; ALUOp=10 in state 6; retired=2 after 8 cycles.
- SW with mem_ready low for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles; RegWrite never asserted; retired increments once.
- FETCH with mem_ready=0 for 2 cycles → IRWrite and PCWrite stay 0 until mem_ready=1, then pulse for exactly 1 cycle.
- BEQ (000100) and J (000010) → BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01; JUMP: PCWrite=1, PCSource=10; each instruction takes 3 cycles.
- Opcode 111111 → illegal_op=1 in DECODE, next state FETCH, retired unchanged. With CNT_W=4, run 16 ADDIs → retired wraps to 0. Drop rst_n in EXEC → state=0 immediately and no RegWrite after release.
